// File: rtl/proc_run_ctrl.sv
// proc_run_ctrl: sequences one program run of the single-cycle core:
// optional image load, held reset, watchdog-bounded run, result capture.
module proc_run_ctrl #(
  parameter int WDOG_LIMIT   = 255,
  parameter int RESET_CYCLES = 2,
  parameter int IMEM_AW      = 6
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               start,
  input  logic               load_en,
  input  logic [63:0]        startpc_in,
  input  logic [63:0]        endpc_in,
  input  logic               load_valid,
  input  logic               load_last,
  input  logic [31:0]        load_data,
  output logic               load_ready,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        imem_wdata,
  output logic               proc_resetl,
  output logic [63:0]        startpc,
  input  logic [63:0]        currentpc,
  input  logic [63:0]        MemtoRegOut,
  output logic               busy,
  output logic               done,
  output logic               timeout,
  output logic               load_err,
  output logic [63:0]        result,
  output logic [15:0]        cycles
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_RESET = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]  state;
  logic [2:0]  nxt;
  logic [63:0] endpc;
  logic [15:0] rcnt;
  logic        go;
  logic        at_end;
  logic        wd_hit;
  logic        full;

  assign go         = start & ((state == S_IDLE) | (state == S_DONE));
  assign imem_we    = (state == S_LOAD) & load_valid;
  assign imem_wdata = load_data;
  assign at_end     = currentpc >= endpc;
  assign wd_hit     = cycles == 16'(WDOG_LIMIT);
  assign full       = imem_addr == '1;

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE, S_DONE:
        if (start) nxt = load_en ? S_LOAD : S_RESET;
      S_LOAD:
        if (imem_we) begin
          if (load_last) nxt = S_RESET;
          else if (full) nxt = S_DONE;
        end
      S_RESET:
        if (rcnt == 16'd0) nxt = S_RUN;
      S_RUN:
        if (at_end || wd_hit) nxt = S_DONE;
      default: nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs are registered from the next state.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      load_ready  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      proc_resetl <= 1'b0;
      imem_addr   <= '0;
      startpc     <= '0;
      endpc       <= '0;
      rcnt        <= '0;
      timeout     <= 1'b0;
      load_err    <= 1'b0;
      result      <= '0;
      cycles      <= '0;
    end else begin
      state       <= nxt;
      load_ready  <= nxt == S_LOAD;
      busy        <= (nxt == S_LOAD) | (nxt == S_RESET) | (nxt == S_RUN);
      done        <= nxt == S_DONE;
      proc_resetl <= nxt == S_RUN;
      if (go) begin
        startpc   <= startpc_in;
        endpc     <= endpc_in;
        timeout   <= 1'b0;
        load_err  <= 1'b0;
        cycles    <= '0;
        imem_addr <= '0;
        rcnt      <= 16'(RESET_CYCLES - 1);
      end
      if (state == S_LOAD && imem_we && !load_last) begin
        if (full) load_err <= 1'b1;
        else imem_addr <= imem_addr + 1'b1;
      end
      if (state == S_RESET) begin
        if (rcnt != 16'd0) rcnt <= rcnt - 16'd1;
        else cycles <= 16'd1;
      end
      if (state == S_RUN) begin
        if (at_end) result <= MemtoRegOut;
        else if (wd_hit) timeout <= 1'b1;
        else if (cycles != 16'hFFFF) cycles <= cycles + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_proc_run_ctrl.sv
// tb_proc_run_ctrl: scoreboard bench with a simple core PC model.
// Expected run outcomes and imem writes are queued at stimulus time.
module tb_proc_run_ctrl;
  localparam int AW = 2;

  logic          CLK = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          load_en = 1'b0;
  logic [63:0]   startpc_in = '0;
  logic [63:0]   endpc_in = '0;
  logic          load_valid = 1'b0;
  logic          load_last = 1'b0;
  logic [31:0]   load_data = '0;
  logic          load_ready, imem_we, proc_resetl;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [63:0]   startpc, currentpc, MemtoRegOut, result;
  logic          busy, done, timeout, load_err;
  logic [15:0]   cycles;

  typedef struct {
    logic [63:0] res;
    logic [15:0] cyc;
    logic        to;
    logic        le;
  } exp_t;
  typedef struct {
    logic [63:0] a;
    logic [31:0] d;
  } w_t;

  exp_t sbq[$];
  w_t   wq[$];
  int   checks = 0;
  int   errors = 0;
  int   rst_total = 0;
  int   run_total = 0;
  logic        loop_mode = 1'b0;
  logic [63:0] cur_epc = '0;
  logic [63:0] cur_final = '0;
  logic [63:0] pc;

  always #5 CLK = ~CLK;

  proc_run_ctrl #(.WDOG_LIMIT(255), .RESET_CYCLES(2), .IMEM_AW(AW)) dut (
    .CLK(CLK), .reset(reset), .start(start), .load_en(load_en),
    .startpc_in(startpc_in), .endpc_in(endpc_in),
    .load_valid(load_valid), .load_last(load_last), .load_data(load_data),
    .load_ready(load_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .proc_resetl(proc_resetl), .startpc(startpc),
    .currentpc(currentpc), .MemtoRegOut(MemtoRegOut), .busy(busy),
    .done(done), .timeout(timeout), .load_err(load_err),
    .result(result), .cycles(cycles)
  );

  always_ff @(posedge CLK) begin
    if (!proc_resetl) pc <= startpc;
    else if (loop_mode && pc == 64'hC) pc <= 64'h8;
    else pc <= pc + 64'd4;
  end
  assign currentpc   = pc;
  assign MemtoRegOut = (pc >= cur_epc) ? cur_final : pc + 64'h1000;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (busy && !proc_resetl && !load_ready) rst_total <= rst_total + 1;
    if (proc_resetl) run_total <= run_total + 1;
  end

  always @(negedge CLK) begin
    w_t w;
    if (!reset && imem_we) begin
      if (wq.size() == 0) chk("wr_extra", 1, 0);
      else begin
        w = wq.pop_front();
        chk("wr_addr", 64'(imem_addr), w.a);
        chk("wr_data", 64'(imem_wdata), w.d);
      end
    end
  end

  task automatic do_start(input logic le, input logic [63:0] epc,
                          input logic lm, input logic [63:0] fin,
                          input exp_t e);
    @(posedge CLK); #1;
    start = 1'b1; load_en = le;
    startpc_in = 64'd0; endpc_in = epc;
    loop_mode = lm; cur_epc = epc; cur_final = fin;
    sbq.push_back(e);
    @(posedge CLK); #1;
    start = 1'b0; load_en = 1'b0;
  endtask

  task automatic feed(input int n, input bit last, input logic [31:0] base);
    chk("load_ready", 64'(load_ready), 1);
    for (int i = 0; i < n; i++) begin
      if (i == 1) begin
        load_valid = 1'b0;
        @(posedge CLK); #1;
      end
      load_valid = 1'b1;
      load_data  = base + 32'(i);
      load_last  = last && (i == n - 1);
      wq.push_back('{a: 64'(i), d: base + 32'(i)});
      @(posedge CLK); #1;
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    exp_t e;
    int k = 0;
    @(negedge CLK);
    while (!done && k < budget) begin
      @(negedge CLK);
      k++;
    end
    chk("done", 64'(done), 1);
    if (done && sbq.size() != 0) begin
      e = sbq.pop_front();
      chk("result", result, e.res);
      chk("cycles", 64'(cycles), 64'(e.cyc));
      chk("timeout", 64'(timeout), 64'(e.to));
      chk("load_err", 64'(load_err), 64'(e.le));
      chk("rstl_done", 64'(proc_resetl), 0);
      chk("busy_done", 64'(busy), 0);
    end
  endtask

  initial begin
    int rb, ub, k;
    repeat (3) @(negedge CLK);
    chk("rst_state", {57'd0, proc_resetl, load_ready, imem_we, busy, done,
                      timeout, load_err}, 0);
    chk("rst_addr", 64'(imem_addr), 0);
    chk("rst_spc", startpc, 0);
    chk("rst_res", result, 0);
    chk("rst_cyc", 64'(cycles), 0);
    @(posedge CLK); #1;
    reset = 1'b0;

    rb = rst_total;
    do_start(1'b1, 64'h30, 1'b0, 64'hF, '{64'hF, 16'd13, 1'b0, 1'b0});
    feed(3, 1'b1, 32'hA);
    wait_done(100);
    chk("rst_len", 64'(rst_total - rb), 2);

    do_start(1'b0, 64'h30, 1'b0, 64'hF, '{64'hF, 16'd13, 1'b0, 1'b0});
    wait_done(100);

    do_start(1'b0, 64'h60, 1'b1, 64'h77, '{64'hF, 16'd255, 1'b1, 1'b0});
    wait_done(400);

    do_start(1'b0, 64'h3F8, 1'b0, 64'hAA, '{64'hAA, 16'd255, 1'b0, 1'b0});
    wait_done(400);

    rb = rst_total;
    ub = run_total;
    do_start(1'b1, 64'h30, 1'b0, 64'hF, '{64'hAA, 16'd0, 1'b0, 1'b1});
    feed(4, 1'b0, 32'h11);
    wait_done(50);
    chk("ovf_no_rst", 64'(rst_total - rb), 0);
    chk("ovf_no_run", 64'(run_total - ub), 0);

    do_start(1'b0, 64'h60, 1'b0, 64'h123456789abcdef0,
             '{64'h0, 16'd0, 1'b0, 1'b0});
    k = 0;
    @(negedge CLK);
    while (cycles != 16'd5 && k < 50) begin
      @(negedge CLK);
      k++;
    end
    chk("mid_cyc5", 64'(cycles), 5);
    reset = 1'b1;
    #1;
    chk("mid_rstl", 64'(proc_resetl), 0);
    chk("mid_busy", 64'(busy), 0);
    chk("mid_stat", {61'd0, done, timeout, load_err}, 0);
    chk("mid_res", result, 0);
    chk("mid_cyc", 64'(cycles), 0);
    sbq.delete();
    @(posedge CLK); #1;
    reset = 1'b0;
    do_start(1'b0, 64'h60, 1'b0, 64'h123456789abcdef0,
             '{64'h123456789abcdef0, 16'd25, 1'b0, 1'b0});
    wait_done(100);

    chk("wq_empty", 64'(wq.size()), 0);
    chk("sbq_empty", 64'(sbq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
